// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan capture block: segment
// patterns (abcdefg, active-high, bit 0 = a), digit codes, capture FSM states
// and small anode-decoding helpers.
package seg_pkg;

    localparam logic [6:0] SEG_PAT_0     = 7'h3F;
    localparam logic [6:0] SEG_PAT_1     = 7'h06;
    localparam logic [6:0] SEG_PAT_2     = 7'h5B;
    localparam logic [6:0] SEG_PAT_3     = 7'h4F;
    localparam logic [6:0] SEG_PAT_4     = 7'h66;
    localparam logic [6:0] SEG_PAT_5     = 7'h6D;
    localparam logic [6:0] SEG_PAT_6     = 7'h7D;
    localparam logic [6:0] SEG_PAT_7     = 7'h07;
    localparam logic [6:0] SEG_PAT_8     = 7'h7F;
    localparam logic [6:0] SEG_PAT_9     = 7'h6F;
    localparam logic [6:0] SEG_PAT_MINUS = 7'h40;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BAD   = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // HUNT doubles as the "waiting for slot 0" state after a completed frame.
    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_CAP1  = 3'd1,
        ST_CAP2  = 3'd2,
        ST_CAP3  = 3'd3,
        ST_CHECK = 3'd4
    } cap_state_e;

    // True when exactly one anode line is driven low.
    function automatic logic anode_onehot_low(input logic [3:0] an);
        logic r;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Slot index of a one-hot-low anode vector (0 for anything else).
    function automatic logic [1:0] anode_slot(input logic [3:0] an);
        logic [1:0] r;
        case (an)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_code.sv
// Combinational decode of an active-low seven-segment pattern into a 4-bit
// digit code; unknown patterns give DIG_BAD with valid low.
module seg7_to_code
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       valid
);

    logic [6:0] lit_s;
    assign lit_s = ~seg;

    // Pattern lookup
    always_comb begin
        code  = DIG_BAD;
        valid = 1'b1;
        case (lit_s)
            SEG_PAT_0:     code = 4'h0;
            SEG_PAT_1:     code = 4'h1;
            SEG_PAT_2:     code = 4'h2;
            SEG_PAT_3:     code = 4'h3;
            SEG_PAT_4:     code = 4'h4;
            SEG_PAT_5:     code = 4'h5;
            SEG_PAT_6:     code = 4'h6;
            SEG_PAT_7:     code = 4'h7;
            SEG_PAT_8:     code = 4'h8;
            SEG_PAT_9:     code = 4'h9;
            SEG_PAT_MINUS: code = DIG_MINUS;
            SEG_PAT_BLANK: code = DIG_BLANK;
            default: begin
                code  = DIG_BAD;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitor for the multiplexed four-digit seven-segment bus. Synchronizes the
// bus, captures each slot once it has settled, and publishes a debounced
// four-digit frame with a one-cycle frame_valid pulse.
// Optional: define SEG_CAPTURE_TIMEOUT_EN to enable the stale-scan detector.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned STABLE_FRAMES = 2
`ifdef SEG_CAPTURE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [3:0] anode,
    input  logic       dp,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp_mask,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_SAT  = SCW'(SETTLE_CYCLES);
    localparam int unsigned MCW = $clog2(STABLE_FRAMES + 1);
    localparam logic [MCW-1:0] MATCH_MAX = MCW'(STABLE_FRAMES);
    localparam logic [MCW-1:0] MATCH_ONE = MCW'(1);
    localparam logic [19:0] FRAME_RESET = {16'hFFFF, 4'h0};

    logic [6:0]  seg_meta_r, seg_sync_r;
    logic [3:0]  anode_meta_r, anode_sync_r;
    logic        dp_meta_r, dp_sync_r;
    logic [11:0] bus_s, bus_prev_r;
    logic [SCW-1:0] settle_cnt_r;
    logic        change_s, anode_chg_s, onehot_s, settled_s, anode_bad_s;
    logic [1:0]  slot_s, exp_slot_s, prev_slot_s;
    logic        hit_exp_s, hit_prev_s, hit_zero_s, hit_other_s;
    logic [3:0]  dec_code_s;
    logic        dec_valid_s;
    cap_state_e  state_r, state_n;
    logic        cap_en_s, err_s, check_s, force_hunt_s;
    logic [3:0]  code_r [4];
    logic [3:0]  fdp_r, fbad_r;
    logic [19:0] frame_s, prev_frame_r, out_frame_r;
    logic [MCW-1:0] match_r, match_next_s;
    logic        frame_bad_s, publish_s, check_err_s;
    logic        frame_valid_r, frame_err_r;

    // Two-flop synchronizers on the display bus
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            seg_meta_r   <= 7'h7F;
            seg_sync_r   <= 7'h7F;
            anode_meta_r <= 4'hF;
            anode_sync_r <= 4'hF;
            dp_meta_r    <= 1'b1;
            dp_sync_r    <= 1'b1;
        end else begin
            seg_meta_r   <= seg;
            seg_sync_r   <= seg_meta_r;
            anode_meta_r <= anode;
            anode_sync_r <= anode_meta_r;
            dp_meta_r    <= dp;
            dp_sync_r    <= dp_meta_r;
        end
    end

    assign bus_s       = {anode_sync_r, seg_sync_r, dp_sync_r};
    assign change_s    = (bus_s != bus_prev_r);
    assign anode_chg_s = (anode_sync_r != bus_prev_r[11:8]);
    assign onehot_s    = anode_onehot_low(anode_sync_r);
    assign slot_s      = anode_slot(anode_sync_r);
    // Saturating one past the settle point makes "settled" a single-cycle event
    // per stable period, so each visit to a slot is captured at most once.
    assign settled_s   = (settle_cnt_r == SETTLE_LAST) && !change_s && onehot_s;
    assign anode_bad_s = anode_chg_s && !onehot_s && (anode_sync_r != 4'hF);

    // Settle counter, restarted by any bus change
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            bus_prev_r   <= {4'hF, 7'h7F, 1'b1};
            settle_cnt_r <= '0;
        end else begin
            bus_prev_r <= bus_s;
            if (change_s) begin
                settle_cnt_r <= '0;
            end else if (settle_cnt_r != SETTLE_SAT) begin
                settle_cnt_r <= settle_cnt_r + SCW'(1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    seg7_to_code u_dec (
        .seg   (seg_sync_r),
        .code  (dec_code_s),
        .valid (dec_valid_s)
    );

    // Slot expected by the current state and the slot captured just before it
    always_comb begin
        case (state_r)
            ST_CAP1: exp_slot_s = 2'd1;
            ST_CAP2: exp_slot_s = 2'd2;
            ST_CAP3: exp_slot_s = 2'd3;
            default: exp_slot_s = 2'd0;
        endcase
    end

    assign prev_slot_s = exp_slot_s - 2'd1;
    assign hit_exp_s   = settled_s && (slot_s == exp_slot_s);
    assign hit_prev_s  = settled_s && (slot_s == prev_slot_s);
    assign hit_zero_s  = settled_s && (slot_s == 2'd0) && (prev_slot_s != 2'd0);
    assign hit_other_s = settled_s && !hit_exp_s && !hit_prev_s && (slot_s != 2'd0);

    // FSM state register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        if (force_hunt_s) begin
            state_n = ST_HUNT;
        end else begin
            case (state_r)
                ST_HUNT:  state_n = hit_exp_s ? ST_CAP1 : ST_HUNT;
                ST_CAP1:  state_n = (anode_bad_s || hit_other_s) ? ST_HUNT :
                                    hit_exp_s ? ST_CAP2 : ST_CAP1;
                ST_CAP2:  state_n = (anode_bad_s || hit_other_s) ? ST_HUNT :
                                    hit_exp_s ? ST_CAP3 :
                                    hit_zero_s ? ST_CAP1 : ST_CAP2;
                ST_CAP3:  state_n = (anode_bad_s || hit_other_s) ? ST_HUNT :
                                    hit_exp_s ? ST_CHECK :
                                    hit_zero_s ? ST_CAP1 : ST_CAP3;
                ST_CHECK: state_n = ST_HUNT;
                default:  state_n = ST_HUNT;
            endcase
        end
    end

    // FSM outputs: capture strobe, abort error, frame check
    always_comb begin
        cap_en_s = 1'b0;
        err_s    = 1'b0;
        check_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                cap_en_s = hit_exp_s && !force_hunt_s;
            end
            ST_CAP1, ST_CAP2, ST_CAP3: begin
                err_s    = !force_hunt_s && (anode_bad_s || hit_other_s || hit_zero_s);
                cap_en_s = !force_hunt_s && !anode_bad_s && (hit_exp_s || hit_zero_s);
            end
            ST_CHECK: begin
                check_s = !force_hunt_s;
            end
            default: begin
                cap_en_s = 1'b0;
            end
        endcase
    end

    // Frame buffer: decoded code, dp and invalid flag per slot
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                code_r[i] <= DIG_BLANK;
            end
            fdp_r  <= 4'h0;
            fbad_r <= 4'h0;
        end else if (cap_en_s) begin
            code_r[slot_s] <= dec_code_s;
            fdp_r[slot_s]  <= ~dp_sync_r;
            fbad_r[slot_s] <= ~dec_valid_s;
        end
    end

    assign frame_s     = {code_r[3], code_r[2], code_r[1], code_r[0], fdp_r};
    assign frame_bad_s = |fbad_r;
    assign check_err_s = check_s && frame_bad_s;

    // Debounce: count consecutive identical good frames
    always_comb begin
        match_next_s = MATCH_ONE;
        if (frame_s == prev_frame_r) begin
            match_next_s = (match_r == MATCH_MAX) ? match_r : (match_r + MCW'(1));
        end else begin
            match_next_s = MATCH_ONE;
        end
    end

    assign publish_s = check_s && !frame_bad_s && (match_next_s == MATCH_MAX)
                       && (frame_s != out_frame_r);

    // Match count and previous-frame register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            match_r      <= '0;
            prev_frame_r <= 20'h0;
        end else if (check_s && !frame_bad_s) begin
            match_r      <= match_next_s;
            prev_frame_r <= frame_s;
        end
    end

    // Registered outputs and status pulses; an error suppresses valid
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            out_frame_r   <= FRAME_RESET;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            frame_err_r   <= err_s || check_err_s;
            frame_valid_r <= publish_s && !(err_s || check_err_s);
            if (publish_s) begin
                out_frame_r <= frame_s;
            end
        end
    end

    assign digit0      = out_frame_r[7:4];
    assign digit1      = out_frame_r[11:8];
    assign digit2      = out_frame_r[15:12];
    assign digit3      = out_frame_r[19:16];
    assign dp_mask     = out_frame_r[3:0];
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_MAX  = TCW'(TIMEOUT_CYCLES);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] to_cnt_r;
    logic           stale_r;

    // Anode inactivity counter and stale flag
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= '0;
            stale_r  <= 1'b0;
        end else if (anode_chg_s) begin
            to_cnt_r <= '0;
            stale_r  <= 1'b0;
        end else begin
            to_cnt_r <= (to_cnt_r == TO_MAX) ? to_cnt_r : (to_cnt_r + TCW'(1));
            stale_r  <= stale_r || (to_cnt_r >= TO_LAST);
        end
    end

    assign force_hunt_s = stale_r && anode_chg_s;
    assign stale        = stale_r;
`else
    assign force_hunt_s = 1'b0;
    assign stale        = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scans plus random frames
// compared against a frame-level reference model of the display debouncer.
module tb_seg_scan_capture;

    localparam int SETTLE = 16;
    localparam int STABLE = 2;
    localparam int HOLD   = 40;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic [6:0] seg    = 7'h7F;
    logic [3:0] anode  = 4'hF;
    logic       dp     = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3, dp_mask;
    logic       frame_valid, frame_err, stale;

    seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE)) dut (
        .clk_in(clk_in), .reset(reset), .seg(seg), .anode(anode), .dp(dp),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_mask(dp_mask), .frame_valid(frame_valid), .frame_err(frame_err),
        .stale(stale)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Pulse monitor (sampled on the falling edge)
    int vcnt = 0, ecnt = 0, both_cnt = 0, last_v_cyc = 0;
    always @(negedge clk_in) begin
        if (frame_valid === 1'b1) begin
            vcnt       <= vcnt + 1;
            last_v_cyc <= cyc;
        end
        if (frame_err === 1'b1) ecnt <= ecnt + 1;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    end

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode table: active-high abcdefg pattern -> digit code
    logic [6:0] pat_tab  [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00};
    logic [3:0] code_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

    function automatic bit decode_ref(input logic [6:0] pat, output logic [3:0] code);
        code = 4'hE;
        for (int i = 0; i < 12; i++) begin
            if (pat_tab[i] == pat) begin
                code = code_tab[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
        return {pat_tab[d], pat_tab[c], pat_tab[b], pat_tab[a]};
    endfunction

    // Frame-level reference model state
    logic [19:0] m_last;
    bit          m_have;
    int          m_run;
    logic [19:0] m_shown;

    task automatic model_reset();
        m_have  = 1'b0;
        m_run   = 0;
        m_last  = 20'h0;
        m_shown = {16'hFFFF, 4'h0};
    endtask

    task automatic drive_slot(input int slot, input logic [6:0] pat, input bit dpb, input int hold);
        anode = ~(4'b0001 << slot);
        seg   = ~pat;
        dp    = ~dpb;
        repeat (hold) @(negedge clk_in);
    endtask

    task automatic run_frame(input string tag, input logic [27:0] pats, input logic [3:0] dps,
                             input int hold);
        int v0, e0, s3, lat;
        logic [3:0] c [4];
        bit bad, exp_v;
        logic [19:0] fr;
        v0 = vcnt;
        e0 = ecnt;
        s3 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) s3 = cyc;
            drive_slot(i, pats[i*7 +: 7], dps[i], hold);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!decode_ref(pats[i*7 +: 7], c[i])) bad = 1'b1;
        end
        exp_v = 1'b0;
        if (!bad) begin
            fr = {c[3], c[2], c[1], c[0], dps};
            if (m_have && fr == m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = fr;
                m_have = 1'b1;
            end
            if (m_run >= STABLE && fr != m_shown) begin
                exp_v   = 1'b1;
                m_shown = fr;
            end
        end
        check({tag, ".valid_pulses"}, vcnt - v0, 32'(exp_v));
        check({tag, ".err_pulses"}, ecnt - e0, 32'(bad));
        check({tag, ".outputs"}, {digit3, digit2, digit1, digit0, dp_mask}, m_shown);
        if (exp_v) begin
            // 2 sync flops + settle window + CHECK + output register
            lat = last_v_cyc - s3;
            n_assert++;
            assert (lat >= SETTLE + 3 && lat <= SETTLE + 4) else begin
                n_fail++;
                $error("FAIL %s.latency: observed %0d expected %0d..%0d", tag, lat,
                       SETTLE + 3, SETTLE + 4);
            end
        end
    endtask

    initial begin
        int v0, e0;
        logic [27:0] rp;
        logic [3:0]  rd;
        int idx;

        model_reset();
        repeat (3) @(negedge clk_in);
        check("rst.digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
        check("rst.dp_mask", dp_mask, 4'h0);
        check("rst.valid", frame_valid, 1'b0);
        check("rst.err", frame_err, 1'b0);
        check("rst.stale", stale, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk_in);

        // Digits 1,2,3,4 with dp in slot 2: valid after the second frame
        run_frame("tp1.f1", pk(1, 2, 3, 4), 4'b0100, HOLD);
        run_frame("tp1.f2", pk(1, 2, 3, 4), 4'b0100, HOLD);
        check("tp1.digits", {digit3, digit2, digit1, digit0}, 16'h4321);
        check("tp1.dp_mask", dp_mask, 4'b0100);

        // Same frame held: no more pulses
        v0 = vcnt;
        for (int k = 0; k < 10; k++) run_frame("tp2.hold", pk(1, 2, 3, 4), 4'b0100, HOLD);
        check("tp2.no_valid", vcnt - v0, 32'd0);

        // Slot 1 changes to 7
        v0 = vcnt;
        run_frame("tp3.f1", pk(1, 7, 3, 4), 4'b0100, HOLD);
        run_frame("tp3.f2", pk(1, 7, 3, 4), 4'b0100, HOLD);
        check("tp3.one_valid", vcnt - v0, 32'd1);
        check("tp3.digit1", digit1, 4'h7);

        // Out-of-order scan 0,1,3 aborts the frame
        v0 = vcnt;
        e0 = ecnt;
        drive_slot(0, pat_tab[1], 1'b0, HOLD);
        drive_slot(1, pat_tab[7], 1'b0, HOLD);
        drive_slot(3, pat_tab[4], 1'b0, HOLD);
        check("tp4.err", ecnt - e0, 32'd1);
        check("tp4.valid", vcnt - v0, 32'd0);
        check("tp4.outputs", {digit3, digit2, digit1, digit0, dp_mask}, m_shown);
        run_frame("tp4.resume", pk(1, 7, 3, 4), 4'b0100, HOLD);
        run_frame("tp4.new1", pk(9, 8, 0, 5), 4'b0001, HOLD);
        run_frame("tp4.new2", pk(9, 8, 0, 5), 4'b0001, HOLD);

        // Undecodable pattern in slot 2
        rp = pk(6, 6, 6, 6);
        rp[20:14] = 7'h55;
        run_frame("tp5.bad1", rp, 4'b0000, HOLD);
        run_frame("tp5.bad2", rp, 4'b0000, HOLD);

        // Reset while waiting for slot 2
        drive_slot(0, pat_tab[3], 1'b0, HOLD);
        drive_slot(1, pat_tab[3], 1'b0, HOLD);
        drive_slot(2, pat_tab[3], 1'b0, 5);
        reset = 1'b0;
        #1;
        check("tp6.digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
        check("tp6.dp_mask", dp_mask, 4'h0);
        check("tp6.valid", frame_valid, 1'b0);
        anode = 4'hF;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_in);
        run_frame("tp6.f1", pk(2, 0, 10, 11), 4'b1000, HOLD);
        run_frame("tp6.f2", pk(2, 0, 10, 11), 4'b1000, HOLD);
        check("tp6.digits_after", {digit3, digit2, digit1, digit0}, 16'hFA02);

        // Random frames, frequently repeated so the debouncer publishes
        rp = pk(0, 0, 0, 0);
        rd = 4'h0;
        for (int k = 0; k < 24; k++) begin
            if (k == 0 || $urandom_range(0, 99) < 45) begin
                for (int s = 0; s < 4; s++) begin
                    idx = $urandom_range(0, 12);
                    rp[s*7 +: 7] = (idx == 12) ? 7'($urandom) : pat_tab[idx];
                end
                rd = 4'($urandom);
            end
            run_frame("rnd", rp, rd, $urandom_range(24, 48));
        end

        check("never_valid_and_err", both_cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
